mux_scan_n: RTL and testbench

MUX_SCAN_N -- requirements
Module: mux_scan_n

---
 rtl/mux_scan_n_if.sv | 36 +++
 rtl/mux_scan_n.sv | 97 +++++++++
 tb/tb_mux_scan_n.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mux_scan_n_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mux_scan_n_if                                             |
// | Brief    : Channel data, select and output handshake bundle for the  |
// |            mux_scan_n sampler.                                       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface mux_scan_n_if #(
   parameter int WIDTH = 3,
   parameter int N     = 8
);
   localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

   logic                 mode;
   logic [SEL_W-1:0]     s;
   logic [N*WIDTH-1:0]   d;
   logic                 en;
   logic                 y_ready;
   logic [WIDTH-1:0]     y;
   logic                 y_valid;
   logic [SEL_W-1:0]     ch;
   logic                 err;

   // Source side: supplies channels/select/requests, consumes samples
   modport master (
      output mode, s, d, en, y_ready,
      input  y, y_valid, ch, err
   );

   // Sampler side
   modport slave (
      input  mode, s, d, en, y_ready,
      output y, y_valid, ch, err
   );
endinterface
`default_nettype wire

// File: rtl/mux_scan_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mux_scan_n                                                |
// | Brief    : N-channel registered sampler with manual select or        |
// |            round-robin scan, valid/ready output hold.                |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module mux_scan_n #(
   parameter int WIDTH = 3,
   parameter int N     = 8,
   localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
   input  wire logic   clk,
   input  wire logic   reset,
   mux_scan_n_if.slave bus
);
   typedef enum logic [0:0] {
      ST_MANUAL = 1'b0,
      ST_SCAN   = 1'b1
   } state_t;

   localparam logic [SEL_W-1:0] c_last = SEL_W'(N - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [SEL_W-1:0]   r_cnt;
   logic [SEL_W-1:0]   w_cnt_nxt;
   logic [WIDTH-1:0]   r_y;
   logic [SEL_W-1:0]   r_ch;
   logic               r_err;
   logic               r_valid;

   logic               w_load;
   logic [SEL_W-1:0]   w_idx;
   logic [WIDTH-1:0]   w_data;
   logic               w_oor;

   // A new sample is accepted when requested and the output slot is free or being drained
   assign w_load = bus.en & (~r_valid | bus.y_ready);

   // Pick the channel index for the current state and fetch its data; out-of-range selects yield zero
   always_comb begin
      w_idx  = (r_state == ST_SCAN) ? r_cnt : bus.s;
      w_oor  = (int'(w_idx) >= N);
      w_data = '0;
      for (int i = 0; i < N; i++) begin
         if (int'(w_idx) == i) begin
            w_data = bus.d[i*WIDTH +: WIDTH];
         end
      end
   end

   // Next state follows mode; scan counter restarts on SCAN entry and steps on each SCAN load
   always_comb begin
      w_state_nxt = bus.mode ? ST_SCAN : ST_MANUAL;
      w_cnt_nxt   = r_cnt;
      if ((r_state == ST_MANUAL) && bus.mode) begin
         w_cnt_nxt = '0;
      end else if ((r_state == ST_SCAN) && w_load) begin
         w_cnt_nxt = (r_cnt == c_last) ? '0 : r_cnt + SEL_W'(1);
      end
   end

   // State and scan counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_MANUAL;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Output sample holding register: load replaces, consume without load clears valid only
   always_ff @(posedge clk) begin
      if (reset) begin
         r_y     <= '0;
         r_ch    <= '0;
         r_err   <= 1'b0;
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_y     <= w_data;
         r_ch    <= w_idx;
         r_err   <= w_oor;
         r_valid <= 1'b1;
      end else if (bus.y_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign bus.y       = r_y;
   assign bus.ch      = r_ch;
   assign bus.err     = r_err;
   assign bus.y_valid = r_valid;
endmodule
`default_nettype wire

// File: tb/tb_mux_scan_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mux_scan_n                                             |
// | Brief    : Directed self-checking bench for mux_scan_n (N=8 and N=6) |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_mux_scan_n;
   logic clk;
   logic reset;
   int   n_vec;
   int   n_miscmp;

   mux_scan_n_if #(.WIDTH(3), .N(8)) bus8 ();
   mux_scan_n_if #(.WIDTH(3), .N(6)) bus6 ();

   mux_scan_n #(.WIDTH(3), .N(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));
   mux_scan_n #(.WIDTH(3), .N(6)) u_dut6 (.clk(clk), .reset(reset), .bus(bus6));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock and settle away from the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miscmp++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input int y, input int ch, input int vld, input int err);
      chk({tag, ".y"},     32'(bus8.y),       32'(y));
      chk({tag, ".ch"},    32'(bus8.ch),      32'(ch));
      chk({tag, ".valid"}, 32'(bus8.y_valid), 32'(vld));
      chk({tag, ".err"},   32'(bus8.err),     32'(err));
   endtask

   task automatic chk6(input string tag, input int y, input int ch, input int vld, input int err);
      chk({tag, ".y"},     32'(bus6.y),       32'(y));
      chk({tag, ".ch"},    32'(bus6.ch),      32'(ch));
      chk({tag, ".valid"}, 32'(bus6.y_valid), 32'(vld));
      chk({tag, ".err"},   32'(bus6.err),     32'(err));
   endtask

   initial begin
      n_vec    = 0;
      n_miscmp = 0;
      for (int i = 0; i < 8; i++) bus8.d[i*3 +: 3] = 3'(i);
      for (int i = 0; i < 6; i++) bus6.d[i*3 +: 3] = 3'(i);

      // Reset with a load requested: reset must win
      reset = 1'b1;
      bus8.mode = 1'b0; bus8.s = 3'd5; bus8.en = 1'b1; bus8.y_ready = 1'b0;
      bus6.mode = 1'b0; bus6.s = 3'd1; bus6.en = 1'b1; bus6.y_ready = 1'b0;
      step();
      step();
      chk8("reset", 0, 0, 0, 0);
      chk6("reset6", 0, 0, 0, 0);

      // First cycle out of reset: manual s=5 sample, then consumed
      reset = 1'b0;
      bus6.en = 1'b0;
      bus8.y_ready = 1'b1;
      step();
      chk8("man5", 5, 5, 1, 0);
      bus8.en = 1'b0;
      step();
      chk8("man5_consumed", 5, 5, 0, 0);

      // Enter SCAN, then stream 10 samples
      bus8.mode = 1'b1;
      step();
      chk("scan_idle.valid", 32'(bus8.y_valid), 32'd0);
      bus8.en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         chk8($sformatf("scan%0d", k), k % 8, k % 8, 1, 0);
      end

      // Back-pressure: sample held, counter frozen
      bus8.y_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk8($sformatf("hold%0d", k), 1, 1, 1, 0);
      end
      bus8.y_ready = 1'b1;
      step();
      chk8("resume", 2, 2, 1, 0);
      step();
      step();
      chk8("at_ch4", 4, 4, 1, 0);

      // Reset mid-scan with en high
      reset = 1'b1;
      step();
      chk8("midreset", 0, 0, 0, 0);
      reset = 1'b0;
      // mode still 1: first load uses MANUAL (s=5), then SCAN restarts at 0
      step();
      chk8("post_reset_man", 5, 5, 1, 0);
      step();
      chk8("rescan0", 0, 0, 1, 0);
      step();
      chk8("rescan1", 1, 1, 1, 0);

      // Toggle MANUAL/SCAN with continuous loads
      bus8.mode = 1'b0; bus8.s = 3'd3;
      step();
      chk8("tog_old_scan", 2, 2, 1, 0);
      step();
      chk8("tog_man3", 3, 3, 1, 0);
      bus8.s = 3'd6;
      step();
      chk8("tog_man6", 6, 6, 1, 0);
      bus8.mode = 1'b1;
      step();
      chk8("tog_old_man", 6, 6, 1, 0);
      step();
      chk8("tog_scan0", 0, 0, 1, 0);
      step();
      chk8("tog_scan1", 1, 1, 1, 0);
      bus8.en = 1'b0;

      // N=6: out-of-range manual select, then in-range
      bus6.mode = 1'b0; bus6.s = 3'd7; bus6.en = 1'b1; bus6.y_ready = 1'b1;
      step();
      chk6("n6_oor", 0, 7, 1, 1);
      bus6.s = 3'd2;
      step();
      chk6("n6_s2", 2, 2, 1, 0);

      // N=6 scan wraps from 5 to 0
      bus6.mode = 1'b1; bus6.en = 1'b0;
      step();
      chk("n6_idle.valid", 32'(bus6.y_valid), 32'd0);
      bus6.en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         chk6($sformatf("n6_scan%0d", k), k % 6, k % 6, 1, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end
endmodule
`default_nettype wire
